case_3_dot_acc_12s_16: RTL and testbench

- Sequential accumulator directly downstream of the case_3 signed 7s x 6s -> 12s multiplier stage.
- Consumes a stream of 12-bit signed products and sums a programmed number of terms into a saturating 16-bit signed dot-product result.
- Presents the result on a valid/ack output handshake.
- Block-level control follows ap_start/ap_done/ap_idle/ap_ready semantics.

---
 rtl/case_3_dot_acc_12s_16_if.sv | 29 ++
 rtl/case_3_dot_acc_12s_16.sv | 134 +++++++++++++
 tb/tb_case_3_dot_acc_12s_16.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/case_3_dot_acc_12s_16_if.sv
// Control, product-stream and result handshake bundle for the dot-product accumulator.
interface case_3_dot_acc_12s_16_if #(
  parameter int unsigned DIN_WIDTH = 12,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 8
);
  logic                        ap_start;
  logic [LEN_WIDTH-1:0]        len;
  logic                        ap_idle;
  logic                        ap_ready;
  logic                        ap_done;
  logic signed [DIN_WIDTH-1:0] prod_din;
  logic                        prod_vld;
  logic                        prod_ack;
  logic signed [ACC_WIDTH-1:0] acc_dout;
  logic                        acc_vld;
  logic                        acc_ack;
  logic                        acc_ovf;

  modport master (
    output ap_start, len, prod_din, prod_vld, acc_ack,
    input  ap_idle, ap_ready, ap_done, prod_ack, acc_dout, acc_vld, acc_ovf
  );

  modport slave (
    input  ap_start, len, prod_din, prod_vld, acc_ack,
    output ap_idle, ap_ready, ap_done, prod_ack, acc_dout, acc_vld, acc_ovf
  );
endinterface

// File: rtl/case_3_dot_acc_12s_16.sv
// Saturating signed dot-product accumulator: sums len products from the multiplier
// and hands the 16-bit result off on a valid/ack handshake.
module case_3_dot_acc_12s_16 #(
  parameter int unsigned DIN_WIDTH = 12,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 8
) (
  input logic                     ap_clk,
  input logic                     ap_rst,
  case_3_dot_acc_12s_16_if.slave  bus
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [1:0]                  state;
  logic [1:0]                  state_nxt;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [LEN_WIDTH-1:0]        count;
  logic signed [ACC_WIDTH-1:0] dout_q;
  logic                        ovf_q;

  logic                        idle_c;
  logic                        ready_c;
  logic                        done_c;
  logic                        pack_c;
  logic                        vld_c;
  logic                        start_c;
  logic                        xfer_c;
  logic                        last_c;

  logic signed [SUM_WIDTH-1:0] sum_c;
  logic signed [ACC_WIDTH-1:0] sum_sat_c;
  logic                        clamp_c;

  // State register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake decode; ap_ready is held low while reset is asserted
  always_comb begin
    state_nxt = state;
    idle_c    = 1'b0;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    pack_c    = 1'b0;
    vld_c     = 1'b0;
    start_c   = 1'b0;
    xfer_c    = 1'b0;
    last_c    = 1'b0;
    case (state)
      S_IDLE: begin
        idle_c = 1'b1;
        if (bus.ap_start && !ap_rst) begin
          ready_c   = 1'b1;
          start_c   = 1'b1;
          state_nxt = (bus.len == '0) ? S_OUTPUT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        pack_c = 1'b1;
        if (bus.prod_vld) begin
          xfer_c = 1'b1;
          if (count == LEN_WIDTH'(1)) begin
            last_c    = 1'b1;
            state_nxt = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        vld_c = 1'b1;
        if (bus.acc_ack) begin
          done_c    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One guard bit above the accumulator is enough to detect either clamp
  always_comb begin
    sum_c = {{(SUM_WIDTH-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q}
          + {{(SUM_WIDTH-DIN_WIDTH){bus.prod_din[DIN_WIDTH-1]}}, bus.prod_din};
    sum_sat_c = sum_c[ACC_WIDTH-1:0];
    clamp_c   = 1'b0;
    if (sum_c > SAT_MAX) begin
      sum_sat_c = ACC_MAX;
      clamp_c   = 1'b1;
    end else if (sum_c < SAT_MIN) begin
      sum_sat_c = ACC_MIN;
      clamp_c   = 1'b1;
    end
  end

  // Datapath: running sum, term counter, and the result register seen by the consumer
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q  <= '0;
      count  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (start_c) begin
      acc_q <= '0;
      count <= bus.len;
      ovf_q <= 1'b0;
      if (bus.len == '0) dout_q <= '0;
    end else if (xfer_c) begin
      acc_q <= sum_sat_c;
      count <= count - LEN_WIDTH'(1);
      if (clamp_c) ovf_q  <= 1'b1;
      if (last_c)  dout_q <= sum_sat_c;
    end
  end

  assign bus.ap_idle  = idle_c;
  assign bus.ap_ready = ready_c;
  assign bus.ap_done  = done_c;
  assign bus.prod_ack = pack_c;
  assign bus.acc_vld  = vld_c;
  assign bus.acc_dout = dout_q;
  assign bus.acc_ovf  = ovf_q;

endmodule

// File: tb/tb_case_3_dot_acc_12s_16.sv
// Directed and randomized checks of the saturating dot-product accumulator against
// a plain-integer reference sum.
module tb_case_3_dot_acc_12s_16;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   terms[$];

  case_3_dot_acc_12s_16_if bus ();

  case_3_dot_acc_12s_16 dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: integer running sum clamped to the 16-bit signed range after every term
  task automatic model(output int res, output int ovf);
    res = 0;
    ovf = 0;
    foreach (terms[k]) begin
      res += terms[k];
      if (res > 32767)  begin res = 32767;  ovf = 1; end
      if (res < -32768) begin res = -32768; ovf = 1; end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idle"},  bus.ap_idle,  1);
    chk({tag, "_ready"}, bus.ap_ready, 0);
    chk({tag, "_done"},  bus.ap_done,  0);
    chk({tag, "_pack"},  bus.prod_ack, 0);
    chk({tag, "_vld"},   bus.acc_vld,  0);
    chk({tag, "_dout"},  bus.acc_dout, 0);
    chk({tag, "_ovf"},   bus.acc_ovf,  0);
  endtask

  // bubble_pct < 0 selects a strict 1,0,1,0 prod_vld pattern
  task automatic do_run(input string tag, input int bubble_pct, input int ack_wait);
    int n, exp_res, exp_ovf, i, budget, ready_cyc, step;
    logic vld;
    n = terms.size();
    model(exp_res, exp_ovf);
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    bus.len      = 8'(n);
    #1;
    chk({tag, "_ready"}, bus.ap_ready, 1);
    chk({tag, "_idle"},  bus.ap_idle,  1);
    ready_cyc = cyc;
    i = 0; budget = 0; step = 0;
    while (i < n && budget < 4000) begin
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      if (bubble_pct < 0) vld = (step % 2 == 0);
      else                vld = (int'($urandom_range(99)) >= bubble_pct);
      bus.prod_vld = vld;
      bus.prod_din = 12'(terms[i]);
      #1;
      if (step == 0) chk({tag, "_pack"}, bus.prod_ack, 1);
      if (vld) i++;
      budget++;
      step++;
    end
    chk({tag, "_terms_sent"}, i, n);
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    bus.prod_vld = 1'b0;
    #1;
    chk({tag, "_vld"},  bus.acc_vld,  1);
    chk({tag, "_dout"}, bus.acc_dout, exp_res);
    chk({tag, "_ovf"},  bus.acc_ovf,  exp_ovf);
    chk({tag, "_pack_out"}, bus.prod_ack, 0);
    for (int w = 0; w < ack_wait; w++) begin
      bus.ap_start = 1'b1;
      #1;
      chk({tag, "_hold_ready"}, bus.ap_ready, 0);
      chk({tag, "_hold_done"},  bus.ap_done,  0);
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      #1;
      chk({tag, "_hold_vld"},  bus.acc_vld,  1);
      chk({tag, "_hold_dout"}, bus.acc_dout, exp_res);
    end
    bus.acc_ack = 1'b1;
    #1;
    chk({tag, "_done"}, bus.ap_done, 1);
    if (bubble_pct == 0 && ack_wait == 0)
      chk({tag, "_latency"}, cyc - ready_cyc + 1, n + 2);
    @(negedge ap_clk);
    bus.acc_ack = 1'b0;
    #1;
    chk({tag, "_post_vld"},  bus.acc_vld,  0);
    chk({tag, "_post_done"}, bus.ap_done,  0);
    chk({tag, "_post_idle"}, bus.ap_idle,  1);
    chk({tag, "_post_dout"}, bus.acc_dout, exp_res);
  endtask

  initial begin
    int nlen, mode;
    bus.ap_start = 1'b0;
    bus.len      = '0;
    bus.prod_din = '0;
    bus.prod_vld = 1'b0;
    bus.acc_ack  = 1'b0;

    @(negedge ap_clk);
    #1;
    chk_reset_outputs("por");
    ap_rst = 1'b0;

    terms = '{10, -3, 2047, -2048};
    do_run("basic", 0, 0);

    terms = {};
    do_run("zero_len", 0, 0);

    terms = {};
    repeat (17) terms.push_back(2047);
    do_run("pos_sat", 0, 0);

    terms = '{5};
    do_run("after_sat", 0, 0);

    // Sixteen -2048 land exactly on the minimum, which is representable (no clamp)
    terms = {};
    repeat (16) terms.push_back(-2048);
    terms.push_back(2047); terms.push_back(2047);
    do_run("neg_exact", 0, 0);

    terms = {};
    repeat (17) terms.push_back(-2048);
    terms.push_back(2047); terms.push_back(2047);
    do_run("neg_sat", 0, 0);

    terms = '{1, 2, 3};
    do_run("stall", -1, 5);

    // Abandon a run with reset raised between clock edges
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    bus.len      = 8'd10;
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      bus.prod_vld = 1'b1;
      bus.prod_din = 12'(k + 100);
    end
    @(negedge ap_clk);
    bus.prod_vld = 1'b0;
    #2 ap_rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge ap_clk);
    ap_rst = 1'b0;

    terms = '{1, 1};
    do_run("post_rst", 0, 0);

    for (int r = 0; r < 10; r++) begin
      terms = {};
      nlen = int'($urandom_range(40));
      mode = int'($urandom_range(2));
      for (int k = 0; k < nlen; k++) begin
        if (mode == 0)      terms.push_back(int'($urandom_range(4095)) - 2048);
        else if (mode == 1) terms.push_back(int'($urandom_range(2047, 1500)));
        else                terms.push_back(-int'($urandom_range(2048, 1500)));
      end
      do_run($sformatf("rand%0d", r), 30, int'($urandom_range(3)));
    end

    // Maximum length: drive into positive clamp, then pull back down
    terms = {};
    for (int k = 0; k < 255; k++)
      terms.push_back(k < 100 ? 2047 : int'($urandom_range(1000)) - 1000);
    do_run("max_len", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
